// File: rtl/vec_wb_arbiter_pkg.sv
// Shared widths, entry packing and source encodings for the vector writeback merge stage.
// Width macros normally come from the shared define.v; these fallbacks are used only when no other file defines them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif

package vec_wb_arbiter_pkg;

  localparam int XLEN_W         = `XLEN;
  localparam int WARP_W         = `DEPTH_WARP;
  localparam int REG_W          = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int NUM_THREAD_DEF = 4;

  // One buffered writeback entry: {data, mask, reg_idxw, warp_id}.
  function automatic int wb_entry_w(input int num_thread);
    return num_thread * XLEN_W + num_thread + REG_W + WARP_W;
  endfunction

  localparam int WB_ENTRY_W = wb_entry_w(NUM_THREAD_DEF);

  typedef enum logic {
    SRC_VMUL = 1'b0,
    SRC_VALU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small power-of-two FIFO with a registered occupancy count and asynchronous active-high reset.
// Head data is read straight from storage, so the output has no path from push-side inputs.
module wb_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap to 0 after DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/vec_wb_arbiter.sv
// Merges the vmul and vector-ALU result streams onto the single vector register-file write port.
// Handshake: a transfer happens on a cycle where valid and ready are both high; a valid source holds its payload until then.
module vec_wb_arbiter
  import vec_wb_arbiter_pkg::*;
#(
  parameter int NUM_THREAD = NUM_THREAD_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s0_valid_i,
  output logic                         s0_ready_o,
  input  logic [NUM_THREAD*XLEN_W-1:0] s0_data_i,
  input  logic [NUM_THREAD-1:0]        s0_mask_i,
  input  logic                         s0_wvd_i,
  input  logic [REG_W-1:0]             s0_reg_idxw_i,
  input  logic [WARP_W-1:0]            s0_warp_id_i,
  input  logic                         s1_valid_i,
  output logic                         s1_ready_o,
  input  logic [NUM_THREAD*XLEN_W-1:0] s1_data_i,
  input  logic [NUM_THREAD-1:0]        s1_mask_i,
  input  logic                         s1_wvd_i,
  input  logic [REG_W-1:0]             s1_reg_idxw_i,
  input  logic [WARP_W-1:0]            s1_warp_id_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [NUM_THREAD*XLEN_W-1:0] wb_data_o,
  output logic [NUM_THREAD-1:0]        wb_mask_o,
  output logic [REG_W-1:0]             wb_reg_idxw_o,
  output logic [WARP_W-1:0]            wb_warp_id_o,
  output logic                         wb_src_o
);

  localparam int ENTRY_W = wb_entry_w(NUM_THREAD);

  logic               s0_push, s1_push;
  logic               s0_pop, s1_pop;
  logic               s0_full, s1_full;
  logic               s0_empty, s1_empty;
  logic [ENTRY_W-1:0] s0_head, s1_head;
  logic [ENTRY_W-1:0] wb_entry;
  logic               wb_fire;
  logic               both_req;
  wb_src_e            grant;
  wb_src_e            rr_prio;
  wb_src_e            hold_src;
  logic               hold;

  // Ready depends only on the registered count (and reset), never on wb_ready_i.
  assign s0_ready_o = ~rst & ~s0_full;
  assign s1_ready_o = ~rst & ~s1_full;

  // Entries that write nothing are accepted and discarded here.
  assign s0_push = s0_valid_i & s0_ready_o & s0_wvd_i & (|s0_mask_i);
  assign s1_push = s1_valid_i & s1_ready_o & s1_wvd_i & (|s1_mask_i);

  wb_skid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo_vmul (
    .clk   (clk),
    .rst   (rst),
    .push  (s0_push),
    .pop   (s0_pop),
    .din   ({s0_data_i, s0_mask_i, s0_reg_idxw_i, s0_warp_id_i}),
    .dout  (s0_head),
    .empty (s0_empty),
    .full  (s0_full)
  );

  wb_skid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo_valu (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_push),
    .pop   (s1_pop),
    .din   ({s1_data_i, s1_mask_i, s1_reg_idxw_i, s1_warp_id_i}),
    .dout  (s1_head),
    .empty (s1_empty),
    .full  (s1_full)
  );

  assign wb_valid_o = ~s0_empty | ~s1_empty;
  assign wb_fire    = wb_valid_o & wb_ready_i;
  assign both_req   = ~s0_empty & ~s1_empty;

  // A stalled grant is pinned: its FIFO cannot drain without a fire, so the held choice stays valid.
  always_comb begin
    grant = rr_prio;
    if (hold)                      grant = hold_src;
    else if (~s0_empty & s1_empty) grant = SRC_VMUL;
    else if (s0_empty & ~s1_empty) grant = SRC_VALU;
  end

  assign s0_pop = wb_fire & (grant == SRC_VMUL);
  assign s1_pop = wb_fire & (grant == SRC_VALU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio  <= SRC_VMUL;
      hold     <= 1'b0;
      hold_src <= SRC_VMUL;
    end else begin
      hold     <= wb_valid_o & ~wb_ready_i;
      hold_src <= grant;
      if (wb_fire & both_req) rr_prio <= wb_src_e'(~grant);
    end
  end

  assign wb_entry = (grant == SRC_VALU) ? s1_head : s0_head;

  always_comb begin
    {wb_data_o, wb_mask_o, wb_reg_idxw_o, wb_warp_id_o} = '0;
    if (wb_valid_o) {wb_data_o, wb_mask_o, wb_reg_idxw_o, wb_warp_id_o} = wb_entry;
  end

  assign wb_src_o = wb_valid_o & (grant == SRC_VALU);

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Bench for vec_wb_arbiter: scripted cycle table, drop/reset sequences, then random traffic against a queue model.
module tb_vec_wb_arbiter;
  import vec_wb_arbiter_pkg::*;

  localparam int NT    = NUM_THREAD_DEF;
  localparam int DEPTH = 2;
  localparam int DW    = NT * XLEN_W;
  localparam int EW    = WB_ENTRY_W;
  localparam int OW    = 4 + EW;

  logic              clk;
  logic              rst;
  logic              s0_valid_i, s0_ready_o, s0_wvd_i;
  logic [DW-1:0]     s0_data_i;
  logic [NT-1:0]     s0_mask_i;
  logic [REG_W-1:0]  s0_reg_idxw_i;
  logic [WARP_W-1:0] s0_warp_id_i;
  logic              s1_valid_i, s1_ready_o, s1_wvd_i;
  logic [DW-1:0]     s1_data_i;
  logic [NT-1:0]     s1_mask_i;
  logic [REG_W-1:0]  s1_reg_idxw_i;
  logic [WARP_W-1:0] s1_warp_id_i;
  logic              wb_valid_o, wb_ready_i, wb_src_o;
  logic [DW-1:0]     wb_data_o;
  logic [NT-1:0]     wb_mask_o;
  logic [REG_W-1:0]  wb_reg_idxw_o;
  logic [WARP_W-1:0] wb_warp_id_o;

  int tests = 0;
  int fails = 0;

  vec_wb_arbiter #(.NUM_THREAD(NT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_valid_i(s0_valid_i), .s0_ready_o(s0_ready_o), .s0_data_i(s0_data_i), .s0_mask_i(s0_mask_i),
    .s0_wvd_i(s0_wvd_i), .s0_reg_idxw_i(s0_reg_idxw_i), .s0_warp_id_i(s0_warp_id_i),
    .s1_valid_i(s1_valid_i), .s1_ready_o(s1_ready_o), .s1_data_i(s1_data_i), .s1_mask_i(s1_mask_i),
    .s1_wvd_i(s1_wvd_i), .s1_reg_idxw_i(s1_reg_idxw_i), .s1_warp_id_i(s1_warp_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o), .wb_mask_o(wb_mask_o),
    .wb_reg_idxw_o(wb_reg_idxw_o), .wb_warp_id_o(wb_warp_id_o), .wb_src_o(wb_src_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  typedef struct {
    int s0v; int s0tag; int s1v; int s1tag; int rdy;
    int ev;  int esrc;  int etag; int er0;  int er1;
  } vec_t;

  vec_t tbl[22];

  // Model state for the random phase
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic          m_prio;
  logic          m_stalled;
  logic          m_last;

  function automatic logic [EW-1:0] tag_entry(input int tag);
    logic [DW-1:0] d;
    for (int l = 0; l < NT; l++) d[l*XLEN_W +: XLEN_W] = XLEN_W'(tag * 16 + l + 1);
    return {d, {NT{1'b1}}, REG_W'(tag + 5), WARP_W'(tag + 2)};
  endfunction

  function automatic vec_t mk(input int s0v, input int s0tag, input int s1v, input int s1tag, input int rdy,
                              input int ev, input int esrc, input int etag, input int er0, input int er1);
    vec_t r;
    r.s0v = s0v; r.s0tag = s0tag; r.s1v = s1v; r.s1tag = s1tag; r.rdy = rdy;
    r.ev = ev; r.esrc = esrc; r.etag = etag; r.er0 = er0; r.er1 = er1;
    return r;
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {wb_valid_o, wb_src_o, s0_ready_o, s1_ready_o, wb_data_o, wb_mask_o, wb_reg_idxw_o, wb_warp_id_o};
  endfunction

  // Scoreboard compare of the whole output bundle {valid, src, ready0, ready1, entry}
  task automatic check(input string name, input logic [OW-1:0] exp);
    logic [OW-1:0] act;
    act = dut_out();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver: check outputs for this cycle, then drive the row inputs through one clock edge
  task automatic apply_row(input vec_t r, input string name);
    logic [EW-1:0] e;
    e = (r.ev != 0) ? tag_entry(r.etag) : '0;
    check(name, {1'(r.ev), 1'(r.esrc), 1'(r.er0), 1'(r.er1), e});
    s0_valid_i = 1'(r.s0v);
    s0_wvd_i   = 1'b1;
    {s0_data_i, s0_mask_i, s0_reg_idxw_i, s0_warp_id_i} = tag_entry(r.s0tag);
    s1_valid_i = 1'(r.s1v);
    s1_wvd_i   = 1'b1;
    {s1_data_i, s1_mask_i, s1_reg_idxw_i, s1_warp_id_i} = tag_entry(r.s1tag);
    wb_ready_i = 1'(r.rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [EW-1:0] rand_entry();
    logic [DW-1:0] d;
    logic [NT-1:0] m;
    for (int l = 0; l < NT; l++) d[l*XLEN_W +: XLEN_W] = XLEN_W'($urandom);
    m = ($urandom_range(0, 7) == 0) ? '0 : NT'($urandom);
    return {d, m, REG_W'($urandom), WARP_W'($urandom)};
  endfunction

  task automatic random_cycle(input int rdy_pct);
    logic          ev, esrc, er0, er1, v0, v1, w0, w1, rdy;
    logic [EW-1:0] e0, e1, eh;
    ev  = (exp_q0.size() > 0) || (exp_q1.size() > 0);
    if (m_stalled)                                    esrc = m_last;
    else if (exp_q0.size() > 0 && exp_q1.size() == 0) esrc = 1'b0;
    else if (exp_q0.size() == 0 && exp_q1.size() > 0) esrc = 1'b1;
    else                                              esrc = m_prio;
    er0 = exp_q0.size() < DEPTH;
    er1 = exp_q1.size() < DEPTH;
    eh  = '0;
    if (ev) eh = esrc ? exp_q1[0] : exp_q0[0];
    check("random", {ev, ev & esrc, er0, er1, eh});

    v0  = $urandom_range(0, 99) < 60;
    v1  = $urandom_range(0, 99) < 60;
    w0  = $urandom_range(0, 9) != 0;
    w1  = $urandom_range(0, 9) != 0;
    e0  = rand_entry();
    e1  = rand_entry();
    rdy = $urandom_range(0, 99) < rdy_pct;
    s0_valid_i = v0; s0_wvd_i = w0; {s0_data_i, s0_mask_i, s0_reg_idxw_i, s0_warp_id_i} = e0;
    s1_valid_i = v1; s1_wvd_i = w1; {s1_data_i, s1_mask_i, s1_reg_idxw_i, s1_warp_id_i} = e1;
    wb_ready_i = rdy;

    if (ev && rdy) begin
      if (exp_q0.size() > 0 && exp_q1.size() > 0) m_prio = ~esrc;
      if (esrc) void'(exp_q1.pop_front());
      else      void'(exp_q0.pop_front());
    end
    m_stalled = ev & ~rdy;
    m_last    = esrc;
    if (v0 && er0 && w0 && (|e0[REG_W+WARP_W +: NT])) exp_q0.push_back(e0);
    if (v1 && er1 && w1 && (|e1[REG_W+WARP_W +: NT])) exp_q1.push_back(e1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    s0_valid_i = 1'b0; s0_wvd_i = 1'b1; s0_data_i = '0; s0_mask_i = '0; s0_reg_idxw_i = '0; s0_warp_id_i = '0;
    s1_valid_i = 1'b0; s1_wvd_i = 1'b1; s1_data_i = '0; s1_mask_i = '0; s1_reg_idxw_i = '0; s1_warp_id_i = '0;
    wb_ready_i = 1'b0;

    tbl[0]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 1, 1);
    tbl[1]  = mk(1, 0, 0, 0, 1,   0, 0, 0, 1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 1,   1, 0, 0, 1, 1);
    tbl[3]  = mk(1, 1, 0, 0, 0,   0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 2, 0, 0, 0,   1, 0, 1, 1, 1);
    tbl[5]  = mk(1, 3, 0, 0, 0,   1, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,   1, 0, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 1,   1, 0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 1,   1, 0, 2, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 1, 1);
    tbl[10] = mk(1, 4, 1, 5, 1,   0, 0, 0, 1, 1);
    tbl[11] = mk(1, 6, 1, 7, 1,   1, 0, 4, 1, 1);
    tbl[12] = mk(1, 8, 1, 9, 1,   1, 1, 5, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 1,   1, 0, 6, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 1,   1, 1, 7, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 1,   1, 0, 8, 1, 1);
    tbl[16] = mk(0, 0, 1, 10, 0,  0, 0, 0, 1, 1);
    tbl[17] = mk(1, 11, 0, 0, 0,  1, 1, 10, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0,   1, 1, 10, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, 1,   1, 1, 10, 1, 1);
    tbl[20] = mk(0, 0, 0, 0, 1,   1, 0, 11, 1, 1);
    tbl[21] = mk(0, 0, 0, 0, 1,   0, 0, 0, 1, 1);

    repeat (2) @(negedge clk);
    check("reset_held", '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 22; i++) apply_row(tbl[i], $sformatf("row%0d", i));

    // Entries with wvd=0 or mask=0 are accepted but never written back
    check("drop_idle", {4'b0011, {EW{1'b0}}});
    s1_valid_i = 1'b1; s1_wvd_i = 1'b0;
    {s1_data_i, s1_mask_i, s1_reg_idxw_i, s1_warp_id_i} = tag_entry(12);
    @(posedge clk); @(negedge clk);
    check("drop_wvd", {4'b0011, {EW{1'b0}}});
    s1_wvd_i = 1'b1; s1_mask_i = '0;
    @(posedge clk); @(negedge clk);
    check("drop_mask", {4'b0011, {EW{1'b0}}});
    s1_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("drop_after", {4'b0011, {EW{1'b0}}});

    // Fill both FIFOs with rr_prio left at 1, then reset mid-operation
    apply_row(mk(1, 13, 1, 14, 1,  0, 0, 0, 1, 1), "rst_a");
    apply_row(mk(0, 0, 0, 0, 1,    1, 0, 13, 1, 1), "rst_b");
    apply_row(mk(1, 15, 1, 16, 0,  1, 1, 14, 1, 1), "rst_c");
    apply_row(mk(1, 19, 1, 20, 0,  1, 1, 14, 1, 0), "rst_d");
    s0_valid_i = 1'b0; s1_valid_i = 1'b0;
    check("rst_full", {4'b1100, tag_entry(14)});
    #2 rst = 1'b1;
    #1 check("rst_async", '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release", {4'b0011, {EW{1'b0}}});
    apply_row(mk(1, 17, 1, 18, 1,  0, 0, 0, 1, 1), "rst_push");
    apply_row(mk(0, 0, 0, 0, 1,    1, 0, 17, 1, 1), "rst_prio");
    apply_row(mk(0, 0, 0, 0, 1,    1, 1, 18, 1, 1), "rst_second");
    apply_row(mk(0, 0, 0, 0, 1,    0, 0, 0, 1, 1), "rst_drained");

    // Random traffic from a clean reset against the queue model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    m_prio = 1'b0; m_stalled = 1'b0; m_last = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 1500; c++) random_cycle(((c / 100) % 3 == 0) ? 20 : 85);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
